// File: rtl/seq_cla_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per
// cycle through one carry-lookahead slice, with valid/ready on both sides.
module seq_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCH = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_cla_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] csum;
  logic             cc;
  logic             cmsb;
  logic             last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (k == KW'(NCH - 1));

  // Lookahead slice over the chunk selected by k, seeded from the carry register
  always_comb begin
    ca   = '0;
    cb   = '0;
    csum = '0;
    cmsb = 1'b0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (k == KW'(j)) begin
        ca = ra[j*CHUNK +: CHUNK];
        cb = rb[j*CHUNK +: CHUNK];
      end
    end
    cc = carry;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      csum[i] = (ca[i] ^ cb[i]) ^ cc;
      if (i == CHUNK - 1) begin
        cmsb = cc;
      end
      cc = (ca[i] & cb[i]) | ((ca[i] ^ cb[i]) & cc);
    end
  end

  // Handshake FSM, operand latch and per-chunk result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            // subtraction is A + ~B + 1: invert B here and fold the 1 into the carry
            rb    <= sub ? ~b : b;
            carry <= cin ^ sub;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned j = 0; j < NCH; j++) begin
            if (k == KW'(j)) begin
              sum[j*CHUNK +: CHUNK] <= csum;
            end
          end
          carry <= cc;
          k     <= k + 1'b1;
          if (last) begin
            cout  <= cc;
            ovf   <= cmsb ^ cc;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cla_adder.sv
// Bench for seq_cla_adder: three instances (16/4, 16/16, 32/8), directed
// vector table, backpressure and mid-run reset sequences, random operations.
module tb_seq_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        cin, sub;
  logic [2:0]  iv, ordy, ir, ov, co, of;
  logic [15:0] s0, s1;
  logic [31:0] s2;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    int unsigned sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  typedef struct {
    int unsigned sel;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  vec_t vt[15];

  always #5 clk = ~clk;

  seq_cla_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0])
  );

  seq_cla_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1])
  );

  seq_cla_adder #(.WIDTH(32), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2])
  );

  function automatic logic [31:0] get_sum(int unsigned sel);
    case (sel)
      0:       return {16'h0, s0};
      1:       return {16'h0, s1};
      default: return s2;
    endcase
  endfunction

  function automatic int unsigned width_of(int unsigned sel);
    return (sel == 2) ? 32 : 16;
  endfunction

  function automatic int unsigned lat_of(int unsigned sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  // Reference: integer arithmetic on unsigned and signed views of the operands
  function automatic exp_t model(int unsigned sel, logic [31:0] ai, logic [31:0] bi,
                                 logic ci, logic si);
    exp_t   r;
    int unsigned w;
    longint full, half, ua, ub, sa, sb, ur, sr, c;
    w    = width_of(sel);
    full = longint'(1) << w;
    half = full >> 1;
    ua   = longint'(ai) & (full - 1);
    ub   = longint'(bi) & (full - 1);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    c    = ci ? 1 : 0;
    if (!si) begin
      ur     = ua + ub + c;
      r.cout = (ur >= full);
      sr     = sa + sb + c;
    end else begin
      ur     = ua - ub - c;
      r.cout = (ua >= ub + c);
      sr     = sa - sb - c;
    end
    if (ur < 0) ur = ur + full;
    ur    = ur % full;
    r.sum = 32'(ur);
    r.ovf = (sr > half - 1) || (sr < -half);
    r.sel = sel;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare whenever a result is being handed off
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (ov[i] && ordy[i]) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("result_inst", 32'(i), 32'(e.sel));
            chk("sum", get_sum(i), e.sum);
            chk("cout", 32'(co[i]), 32'(e.cout));
            chk("ovf", 32'(of[i]), 32'(e.ovf));
          end
        end
      end
    end
  end

  task automatic run_op(input int unsigned sel, input logic [31:0] ai, input logic [31:0] bi,
                        input logic ci, input logic si, input exp_t e, input bit hold);
    int unsigned lat;
    q.push_back(e);
    @(posedge clk); #1;
    a = ai; b = bi; cin = ci; sub = si;
    iv[sel] = 1'b1;
    chk("in_ready_idle", 32'(ir[sel]), 32'd1);
    @(posedge clk); #1;
    iv[sel] = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!ov[sel] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, lat_of(sel));
    if (hold) begin
      for (int n = 0; n < 3; n++) begin
        a = $urandom; b = $urandom; iv[sel] = ~iv[sel];
        @(posedge clk); #1;
        chk("hold_sum", get_sum(sel), e.sum);
        chk("hold_cout", 32'(co[sel]), 32'(e.cout));
        chk("hold_ovf", 32'(of[sel]), 32'(e.ovf));
        chk("hold_in_ready", 32'(ir[sel]), 32'd0);
        chk("hold_out_valid", 32'(ov[sel]), 32'd1);
      end
      iv[sel] = 1'b0;
    end
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    if (hold) begin
      chk("in_ready_after_handoff", 32'(ir[sel]), 32'd1);
      chk("out_valid_after_handoff", 32'(ov[sel]), 32'd0);
    end
  endtask

  function automatic exp_t vexp(vec_t v);
    exp_t e;
    e.sel = v.sel; e.sum = v.esum; e.cout = v.ecout; e.ovf = v.eovf;
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{0, 32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0};
    vt[1]  = '{0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0};
    vt[2]  = '{0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
    vt[3]  = '{0, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0};
    vt[4]  = '{0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1};
    vt[5]  = '{0, 32'h0005, 32'h0002, 1'b1, 1'b1, 32'h0002, 1'b1, 1'b0};
    vt[6]  = '{1, 32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0};
    vt[7]  = '{1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0};
    vt[8]  = '{1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
    vt[9]  = '{1, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0};
    vt[10] = '{1, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1};
    vt[11] = '{1, 32'h0005, 32'h0002, 1'b1, 1'b1, 32'h0002, 1'b1, 1'b0};
    vt[12] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[13] = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[14] = '{2, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1; iv = '0; ordy = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 3; i++) begin
      chk("reset_in_ready", 32'(ir[i]), 32'd1);
      chk("reset_out_valid", 32'(ov[i]), 32'd0);
      chk("reset_sum", get_sum(i), 32'd0);
      chk("reset_cout", 32'(co[i]), 32'd0);
      chk("reset_ovf", 32'(of[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vexp(vt[i]), 1'b0);
    end

    // Backpressure on the chunked and single-cycle instances
    run_op(0, 32'h1F0F, 32'h2222, 1'b1, 1'b0, model(0, 32'h1F0F, 32'h2222, 1'b1, 1'b0), 1'b1);
    run_op(1, 32'h8001, 32'h0002, 1'b0, 1'b1, model(1, 32'h8001, 32'h0002, 1'b0, 1'b1), 1'b1);

    // Reset while RUN is on chunk 2: operation must vanish
    @(posedge clk); #1;
    a = 32'h0000_ABCD; b = 32'h0000_1111; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_reset_in_ready", 32'(ir[0]), 32'd1);
    chk("midrun_reset_out_valid", 32'(ov[0]), 32'd0);
    chk("midrun_reset_sum", {16'h0, s0}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("midrun_no_result", 32'(ov[0]), 32'd0);
    run_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, '{0, 32'h5555, 1'b0, 1'b0}, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      int unsigned sel;
      logic [31:0] ra, rb;
      logic rc, rs;
      sel = $urandom_range(0, 2);
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      if (n % 10 == 0) rb = ra;
      run_op(sel, ra, rb, rc, rs, model(sel, ra, rb, rc, rs), 1'b0);
    end

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
